// File: rtl/calibration_char_source.sv
// calibration_char_source: FIFO-backed char_in/input_valid transmitter with idle gaps and auto newline per line.
// Optional macro STRIP_CR_EN drops 0x0D bytes from the emitted stream.
module calibration_char_source #(
    parameter int DEPTH      = 256,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [7:0]  wr_char,
    input  logic        wr_last,
    output logic        wr_ready,
    input  logic        eos,
    input  logic        tx_enable,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic [31:0] chars_sent,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [GW-1:0] GAP_M1 = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SEND   = 3'd1;
    localparam logic [2:0] GAP    = 3'd2;
    localparam logic [2:0] NL     = 3'd3;
    localparam logic [2:0] NL_GAP = 3'd4;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic [2:0]    state;
    logic [GW-1:0] gap_cnt;
    logic          eos_q, nl_pend, done_q;
    logic          push, pop, free, can_pop, is_cr, head_last;
    logic [7:0]    head_char;

    assign wr_ready  = !eos_q && cnt != (AW+1)'(DEPTH);
    assign push      = wr_valid && wr_ready;
    assign {head_last, head_char} = mem[rptr];
    assign can_pop   = tx_enable && cnt != '0;
    // free: the FSM may start a newline or a new character this cycle
    assign free      = state == IDLE
                    || (GAP_CYCLES == 0 && (state == SEND || state == NL))
                    || ((state == GAP || state == NL_GAP) && gap_cnt == '0);
    assign pop       = free && !nl_pend && can_pop;
`ifdef STRIP_CR_EN
    assign is_cr     = head_char == 8'h0D;
`else
    assign is_cr     = 1'b0;
`endif
    assign done      = done_q || (state == IDLE && cnt == '0 && eos_q && !nl_pend);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {wr_last, wr_char};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            eos_q      <= 1'b0;
            done_q     <= 1'b0;
            state      <= IDLE;
            nl_pend    <= 1'b0;
            gap_cnt    <= '0;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            chars_sent <= 32'd0;
        end else begin
            wptr   <= wptr + AW'(push);
            rptr   <= rptr + AW'(pop);
            cnt    <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            eos_q  <= eos_q | eos;
            done_q <= done;
            if (free && nl_pend) begin
                state      <= NL;
                char_valid <= 1'b1;
                char_out   <= 8'h0A;
                chars_sent <= chars_sent + 32'd1;
                nl_pend    <= 1'b0;
            end else if (pop && is_cr) begin
                state      <= IDLE;
                char_valid <= 1'b0;
                nl_pend    <= head_last;
            end else if (pop) begin
                state      <= SEND;
                char_valid <= 1'b1;
                char_out   <= head_char;
                chars_sent <= chars_sent + 32'd1;
                nl_pend    <= head_last && head_char != 8'h0A;
            end else if (free) begin
                state      <= IDLE;
                char_valid <= 1'b0;
            end else begin
                state      <= state == SEND ? GAP : state == NL ? NL_GAP : state;
                gap_cnt    <= (state == SEND || state == NL) ? GAP_M1 : gap_cnt - 1'b1;
                char_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_calibration_char_source.sv
// tb_calibration_char_source: directed and randomized checks of the character transmitter against a stream model.
module tb_calibration_char_source;
    localparam int GAP = 1;
    localparam int DEPTH = 256;
`ifdef STRIP_CR_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, wr_last = 1'b0, eos = 1'b0, tx_enable = 1'b0;
    logic [7:0]  wr_char = 8'h00;
    logic        wr_ready, char_valid, done;
    logic [7:0]  char_out;
    logic [31:0] chars_sent;
    int          compared = 0, mismatched = 0, cyc = 0;
    logic [7:0]  obs_q[$], exp_q[$];
    int          obs_t[$];

    calibration_char_source #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char), .wr_last(wr_last),
        .wr_ready(wr_ready), .eos(eos), .tx_enable(tx_enable), .char_out(char_out),
        .char_valid(char_valid), .chars_sent(chars_sent), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst && char_valid) begin
        obs_q.push_back(char_out);
        obs_t.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream model: each line entry yields its byte (unless stripped) plus a newline when it closes a line.
    task automatic model_push(input logic [7:0] c, input logic l);
        if (!(STRIP && c == 8'h0D)) exp_q.push_back(c);
        if (l && c != 8'h0A) exp_q.push_back(8'h0A);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; eos = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        obs_q.delete(); obs_t.delete(); exp_q.delete();
    endtask

    task automatic wr(input logic [7:0] c, input logic l, input logic acc);
        chk("wr_ready", 32'(wr_ready), 32'(acc));
        wr_valid = 1'b1; wr_char = c; wr_last = l;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        if (acc) model_push(c, l);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (4 * GAP + 6) @(posedge clk);
        #1;
        chk({tag, " pulses"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, " char"}, 32'(obs_q[i]), 32'(exp_q[i]));
        chk({tag, " chars_sent"}, chars_sent, 32'(exp_q.size()));
    endtask

    initial begin
        int a, n, td, viol;
        logic [7:0] c;
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int a, n, td, viol;
        logic [7:0] c;
        do_reset();
        chk("reset char_valid", 32'(char_valid), 0);
        chk("reset char_out", 32'(char_out), 0);
        chk("reset chars_sent", chars_sent, 0);
        chk("reset done", 32'(done), 0);
        chk("reset wr_ready", 32'(wr_ready), 1);

        // line "1a2" with back-to-back writes
        tx_enable = 1'b1;
        wr("1", 1'b0, 1'b1);
        a = cyc;
        wr("a", 1'b0, 1'b1);
        wr("2", 1'b1, 1'b1);
        drain(50, "t1");
        if (obs_t.size() > 0) chk("t1 latency", 32'(obs_t[0]), 32'(a + 1));
        for (int i = 1; i < obs_t.size(); i++) chk("t1 spacing", 32'(obs_t[i] - obs_t[i-1]), 32'(GAP + 1));

        // empty line
        do_reset();
        tx_enable = 1'b1;
        wr(8'h0A, 1'b1, 1'b1);
        drain(20, "t2");

        // fill to full with transmit held off
        do_reset();
        tx_enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr(8'($urandom_range(0, 255)) == 8'h0A ? 8'h41 : 8'($urandom_range(32, 126)), 1'b0, 1'b1);
        wr(8'h5A, 1'b0, 1'b0);
        chk("t3 held", 32'(obs_q.size()), 0);
        tx_enable = 1'b1;
        drain(DEPTH * (GAP + 1) + 20, "t3");
        chk("t3 wr_ready after drain", 32'(wr_ready), 1);

        // end of stream
        do_reset();
        tx_enable = 1'b1;
        wr("5", 1'b0, 1'b1);
        wr("x", 1'b1, 1'b1);
        eos = 1'b1;
        @(posedge clk);
        #1 eos = 1'b0;
        chk("t4 wr_ready after eos", 32'(wr_ready), 0);
        chk("t4 done early", 32'(done), 0);
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        td = cyc;
        chk("t4 done", 32'(done), 1);
        chk("t4 pulses at done", 32'(obs_q.size()), 3);
        if (obs_t.size() > 0) chk("t4 done delay", 32'(td - obs_t[obs_t.size()-1]), 32'(GAP + 1));
        drain(20, "t4");
        chk("t4 done sticky", 32'(done), 1);
        wr("q", 1'b0, 1'b0);

        // reset during second char of a line
        do_reset();
        tx_enable = 1'b1;
        wr("a", 1'b0, 1'b1);
        wr("b", 1'b0, 1'b1);
        wr("c", 1'b1, 1'b1);
        n = 0;
        while (!(char_valid && obs_q.size() == 1) && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("t5 reached 2nd char", 32'(char_out), 32'("b"));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 char_valid", 32'(char_valid), 0);
        chk("t5 chars_sent", chars_sent, 0);
        chk("t5 done", 32'(done), 0);
        chk("t5 wr_ready", 32'(wr_ready), 1);
        rst = 1'b0;
        obs_q.delete(); obs_t.delete(); exp_q.delete();
        repeat (20) @(posedge clk);
        #1 chk("t5 silent", 32'(obs_q.size()), 0);

        // carriage return handling
        do_reset();
        tx_enable = 1'b1;
        wr("7", 1'b0, 1'b1);
        wr(8'h0D, 1'b1, 1'b1);
        drain(30, "t6");

        // randomized lines with tx_enable toggling
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tx_enable = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 9);
            c = n == 0 ? 8'h0A : n == 1 ? 8'h0D : 8'($urandom_range(32, 126));
            wr(c, $urandom_range(0, 3) == 0, 1'b1);
            n = $urandom_range(0, 2);
            if (n > 0) begin
                repeat (n) @(posedge clk);
                #1;
            end
        end
        tx_enable = 1'b1;
        drain(400, "rand");
        viol = 0;
        for (int i = 1; i < obs_t.size(); i++) if (obs_t[i] - obs_t[i-1] < GAP + 1) viol++;
        chk("rand spacing", 32'(viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
